fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arb_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 64 ++++++
 rtl/fpu_arbiter.sv | 147 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU arbiter: FSM state encoding,
// one-hot FPU status codes and the custom 32-bit float field layout.
package fpu_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // One-hot FPU status codes
    localparam logic [3:0] StatusExact     = 4'b0001;
    localparam logic [3:0] StatusInexact   = 4'b0010;
    localparam logic [3:0] StatusOverflow  = 4'b0100;
    localparam logic [3:0] StatusUnderflow = 4'b1000;

    // Float layout: sign[31], exponent[30:25] (bias 31), mantissa[24:0]
    localparam int unsigned FpSignW = 1;
    localparam int unsigned FpExpW  = 6;
    localparam int unsigned FpManW  = 25;
    localparam int unsigned FpBias  = 31;
    localparam int unsigned FpWidth = FpSignW + FpExpW + FpManW;

    // Wait counter width, covers WAIT_CYCLES up to 255
    localparam int unsigned CntW = 8;

    // True when a status word carries exactly one flag
    function automatic logic status_is_onehot(input logic [3:0] status);
        return (status == StatusExact) || (status == StatusInexact) ||
               (status == StatusOverflow) || (status == StatusUnderflow);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: combinational grant plus a registered priority pointer.
// Build option: define FPU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins, no pointer kept); otherwise round-robin.
module rr_arb2 (
    input  logic       clock100KHz,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

`ifdef FPU_ARB_FIXED_PRIO_EN

    // Fixed priority: requester 0 wins any tie
    always_comb begin
        gnt_id = ~req[0] & req[1];
        gnt    = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

`else

    // prio_q names the requester that wins a tie; 0 after reset
    logic prio_q, prio_d;

    // Round-robin grant: on a tie the pointer decides, otherwise the lone requester
    always_comb begin
        if (req == 2'b11) begin
            gnt_id = prio_q;
        end else begin
            gnt_id = req[1];
        end
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves away from the requester whose response was just consumed
    always_comb begin
        prio_d = prio_q;
        if (upd_en) begin
            prio_d = ~upd_id;
        end
    end

    // Pointer register
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

`endif

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one multi-cycle FPU between two requesters. A granted request's
// operands are held on the FPU for WAIT_CYCLES cycles, then the FPU result
// is captured and presented on a valid/ready response port.
// Build option: FPU_ARB_FIXED_PRIO_EN selects fixed priority (see rr_arb2).
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 40
) (
    input  logic                clock100KHz,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [FpWidth-1:0]  req0_a,
    input  logic [FpWidth-1:0]  req0_b,
    input  logic [FpWidth-1:0]  req1_a,
    input  logic [FpWidth-1:0]  req1_b,
    output logic [FpWidth-1:0]  fpu_op_a,
    output logic [FpWidth-1:0]  fpu_op_b,
    input  logic [FpWidth-1:0]  fpu_data_in,
    input  logic [3:0]          fpu_status_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [FpWidth-1:0]  rsp_data,
    output logic [3:0]          rsp_status,
    output logic                busy
);

    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [FpWidth-1:0] op_a_q, op_a_d;
    logic [FpWidth-1:0] op_b_q, op_b_d;
    logic [FpWidth-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]         rsp_status_q, rsp_status_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               pend_id_q, pend_id_d;

    logic [1:0]         arb_gnt;
    logic               arb_gnt_id;
    logic               arb_upd;
    logic               accept;

    rr_arb2 u_rr_arb2 (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .req         ({req1_valid, req0_valid}),
        .upd_en      (arb_upd),
        .upd_id      (rsp_id_q),
        .gnt         (arb_gnt),
        .gnt_id      (arb_gnt_id)
    );

    // A grant is only offered in IDLE; gating with reset keeps ready low while held in reset
    assign accept = (state_q == StIdle) && reset && (arb_gnt != 2'b00);

    // Next-state and handshake logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        pend_id_d    = pend_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        arb_upd      = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    req0_ready = arb_gnt[0];
                    req1_ready = arb_gnt[1];
                    op_a_d     = arb_gnt_id ? req1_a : req0_a;
                    op_b_d     = arb_gnt_id ? req1_b : req0_b;
                    pend_id_d  = arb_gnt_id;
                    cnt_d      = CntLoad;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_data_d   = fpu_data_in;
                    rsp_status_d = fpu_status_in;
                    rsp_id_d     = pend_id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                // Response fields stay frozen until consumed; no grant in the consuming cycle
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    arb_upd     = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            pend_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each consumed response.
module tb_fpu_arbiter;

    localparam int unsigned Wait = 40;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [3:0]  status;
    } rsp_t;

    logic        clock100KHz = 1'b0;
    logic        reset       = 1'b0;
    logic        req0_valid  = 1'b0;
    logic        req1_valid  = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_ready   = 1'b1;
    logic        use_model   = 1'b0;
    logic [31:0] stub_data   = '0;
    logic [3:0]  stub_status = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [31:0] fpu_op_a, fpu_op_b, rsp_data, fpu_data_in;
    logic [3:0]  rsp_status, fpu_status_in;

    rsp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Fake FPU: fixed stub value, or sum of the operands it is being shown
    assign fpu_data_in   = use_model ? (fpu_op_a + fpu_op_b) : stub_data;
    assign fpu_status_in = use_model ? 4'b0010 : stub_status;

    fpu_arbiter #(.WAIT_CYCLES(Wait)) dut (
        .clock100KHz   (clock100KHz),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .busy          (busy)
    );

    always #5 clock100KHz = ~clock100KHz;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock100KHz);
        #1;
    endtask

    task automatic wait_grant(output logic id, output logic ok);
        ok = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock100KHz);
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                id = req1_ready;
                return;
            end
        end
        n_vec++;
        n_miss++;
        $display("FAIL grant_timeout: got no ready expected a grant");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock100KHz);
            if (exp_q.size() == 0 && !rsp_valid) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    endtask

    // Monitor: every consumed response must match the head of the scoreboard
    always @(negedge clock100KHz) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got id %0d data %h expected none", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 128'(rsp_id), 128'(e.id));
                check("rsp_data", 128'(rsp_data), 128'(e.data));
                check("rsp_status", 128'(rsp_status), 128'(e.status));
            end
        end
    end

    initial begin
        logic g, ok;
        int   n;
        rsp_t e;
        logic exp_order [4];

        // ---- reset state, with both valids pushing ----
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clock100KHz);
        check("reset_outputs",
              128'({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_status,
                    rsp_data, fpu_op_a, fpu_op_b}), 128'(0));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b1;

        // ---- single request, latency ----
        tick();
        stub_data   = 32'h4000_0000;
        stub_status = 4'b0001;
        req0_a      = 32'h3E00_0000;
        req0_b      = 32'h3E00_0000;
        req0_valid  = 1'b1;
        wait_grant(g, ok);
        check("t1_grant_id", 128'(g), 128'(0));
        exp_q.push_back('{id: 1'b0, data: 32'h4000_0000, status: 4'b0001});
        tick();
        req0_valid = 1'b0;
        @(negedge clock100KHz);
        n = 1;
        check("t1_ready_once", 128'({req0_ready, req1_ready, busy}), 128'(3'b001));
        check("t1_op_regs", 128'({fpu_op_a, fpu_op_b}), 128'({32'h3E00_0000, 32'h3E00_0000}));
        while (!rsp_valid && n < 300) begin
            @(negedge clock100KHz);
            n++;
        end
        check("t1_latency", 128'(n), 128'(Wait + 1));
        @(negedge clock100KHz);
        check("t1_idle_after", 128'({busy, rsp_valid}), 128'(0));
        check("t1_ops_held", 128'(fpu_op_a), 128'(32'h3E00_0000));

        // ---- backpressure, with req0 pending meanwhile ----
        tick();
        rsp_ready   = 1'b0;
        stub_data   = 32'h1234_5678;
        stub_status = 4'b0010;
        req1_a      = 32'h1111_1111;
        req1_b      = 32'h2222_2222;
        req1_valid  = 1'b1;
        wait_grant(g, ok);
        check("t2_grant_id", 128'(g), 128'(1));
        exp_q.push_back('{id: 1'b1, data: 32'h1234_5678, status: 4'b0010});
        tick();
        req1_valid = 1'b0;
        req0_a     = 32'h3F00_0000;
        req0_b     = 32'h0100_0000;
        req0_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clock100KHz);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("t2_stall_stable",
                  128'({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_status, rsp_data}),
                  128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h1234_5678}));
            if (i < 9) @(negedge clock100KHz);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clock100KHz);
        check("t2_no_grant_on_release", 128'({req0_ready, req1_ready, busy}), 128'(3'b001));
        @(negedge clock100KHz);
        check("t2_idle_then_grant", 128'({busy, rsp_valid, req0_ready}), 128'(3'b001));
        exp_q.push_back('{id: 1'b0, data: 32'h1234_5678, status: 4'b0010});
        tick();
        req0_valid = 1'b0;
        wait_drain();

        // ---- reset in the middle of WAIT ----
        tick();
        stub_data   = 32'hDEAD_BEEF;
        stub_status = 4'b0001;
        req0_a      = 32'hAAAA_0000;
        req0_b      = 32'h0000_5555;
        req0_valid  = 1'b1;
        wait_grant(g, ok);
        tick();
        req0_valid = 1'b0;
        repeat (20) @(negedge clock100KHz);
        tick();
        reset = 1'b0;
        @(negedge clock100KHz);
        check("t3_reset_outputs",
              128'({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_status,
                    rsp_data, fpu_op_a, fpu_op_b}), 128'(0));
        tick();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock100KHz);
            if (rsp_valid) n++;
        end
        check("t3_no_response", 128'(n), 128'(0));

        // ---- new request after reset, overflow status pass-through ----
        tick();
        stub_data   = 32'h7FFF_FFFF;
        stub_status = 4'b0100;
        req0_a      = 32'h7E00_0000;
        req0_b      = 32'h7E00_0000;
        req0_valid  = 1'b1;
        wait_grant(g, ok);
        check("t4_grant_id", 128'(g), 128'(0));
        exp_q.push_back('{id: 1'b0, data: 32'h7FFF_FFFF, status: 4'b0100});
        tick();
        req0_valid = 1'b0;
        wait_drain();

        // ---- simultaneous requests held from reset ----
`ifdef FPU_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        tick();
        reset      = 1'b0;
        use_model  = 1'b1;
        req0_a     = 32'h0000_0100;
        req0_b     = 32'h0000_0001;
        req1_a     = 32'h0000_0200;
        req1_b     = 32'h0000_0002;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, ok);
            if (!ok) break;
            check("t5_grant_onehot", 128'({req1_ready, req0_ready}),
                  128'(exp_order[k] ? 2'b10 : 2'b01));
            e.id     = exp_order[k];
            e.data   = exp_order[k] ? (req1_a + req1_b) : (req0_a + req0_b);
            e.status = 4'b0010;
            exp_q.push_back(e);
            tick();
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else if (g) begin
                req1_a = req1_a + 32'h10;
            end else begin
                req0_a = req0_a + 32'h10;
            end
        end
        wait_drain();
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
